pipe_adder: RTL and testbench

//   Parametrised, pipelined add/subtract unit for the datapath ALU and

---
 rtl/pipe_adder_pkg.sv | 11 +
 rtl/pipe_adder_chunk.sv | 18 +
 rtl/pipe_adder.sv | 167 ++++++++++++++++
 tb/tb_pipe_adder.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_adder_pkg.sv
// Shared flag layout for the pipelined adder, the ALU and condition-check logic.
package pipe_adder_pkg;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef logic [3:0] flags_t;

endpackage

// File: rtl/pipe_adder_chunk.sv
// Combinational W-bit add slice; one instance per pipeline stage of pipe_adder.
module adder_chunk #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  logic [W:0] w_total;

  assign w_total = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
  assign sum     = w_total[W-1:0];
  assign cout    = w_total[W];

endmodule

// File: rtl/pipe_adder.sv
// Pipelined add/subtract: the carry chain is cut into STAGES registered slices.
// Optional NZCV flags are built only when PIPE_ADDER_FLAGS_EN is defined.
module pipe_adder
  import pipe_adder_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output flags_t           out_flags
);

  localparam int SDIV = (STAGES < 1) ? 1 : STAGES;
  localparam int C    = WIDTH / SDIV;

  if (STAGES < 1 || (WIDTH % SDIV) != 0 || WIDTH < 2) begin : g_bad_cfg
    $error("pipe_adder: WIDTH must be >= 2 and divisible by STAGES >= 1");
  end

`ifdef PIPE_ADDER_FLAGS_EN
  function automatic flags_t calc_flags(input logic [WIDTH-1:0] s, input logic c,
                                        input logic a_msb, input logic b_msb);
    flags_t f;
    f         = '0;
    f[FLAG_N] = s[WIDTH-1];
    f[FLAG_Z] = (s == '0);
    f[FLAG_C] = c;
    f[FLAG_V] = (a_msb == b_msb) && (s[WIDTH-1] != a_msb);
    return f;
  endfunction
`endif

  logic [STAGES-1:0] r_vld;
  logic [STAGES-1:0] w_vld_src;
  logic [STAGES:0]   w_adv;
  logic [WIDTH-1:0]  w_b_eff;

  assign w_b_eff       = in_b ^ {WIDTH{in_sub}};
  assign w_adv[STAGES] = out_ready;
  assign in_ready      = w_adv[0];
  assign out_valid     = r_vld[STAGES-1];

  // A stage moves when empty or when its successor moves, so bubbles collapse.
  for (genvar k = 0; k < STAGES; k++) begin : g_adv
    assign w_adv[k] = ~r_vld[k] | w_adv[k+1];
  end

  if (STAGES == 1) begin : g_vsrc
    assign w_vld_src = in_valid;
  end else begin : g_vsrc
    assign w_vld_src = {r_vld[STAGES-2:0], in_valid};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_vld <= '0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (w_adv[k]) r_vld[k] <= w_vld_src[k];
      end
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int SW = (k + 1) * C;

    logic [C-1:0]  w_a;
    logic [C-1:0]  w_b;
    logic [C-1:0]  w_sum;
    logic          w_cin;
    logic          w_cout;
    logic [SW-1:0] w_acc;
    logic [SW-1:0] r_sum;
    logic          r_cy;

    // stage k boundary: operands come from the input port or the previous stage
    if (k == 0) begin : g_src
      assign w_a   = in_a[C-1:0];
      assign w_b   = w_b_eff[C-1:0];
      assign w_cin = in_sub | in_cin;
      assign w_acc = w_sum;
    end else begin : g_src
      assign w_a   = g_stage[k-1].g_rem.r_a[C-1:0];
      assign w_b   = g_stage[k-1].g_rem.r_b[C-1:0];
      assign w_cin = g_stage[k-1].r_cy;
      assign w_acc = {w_sum, g_stage[k-1].r_sum};
    end

    adder_chunk #(.W(C)) u_chunk (
      .a    (w_a),
      .b    (w_b),
      .cin  (w_cin),
      .sum  (w_sum),
      .cout (w_cout)
    );

    if (k < STAGES - 1) begin : g_rem
      localparam int RW = WIDTH - SW;

      logic [RW-1:0] r_a;
      logic [RW-1:0] r_b;
      logic [RW-1:0] w_a_nx;
      logic [RW-1:0] w_b_nx;

      if (k == 0) begin : g_nx
        assign w_a_nx = in_a[WIDTH-1:C];
        assign w_b_nx = w_b_eff[WIDTH-1:C];
      end else begin : g_nx
        assign w_a_nx = g_stage[k-1].g_rem.r_a[RW+C-1:C];
        assign w_b_nx = g_stage[k-1].g_rem.r_b[RW+C-1:C];
      end

      always_ff @(posedge clk) begin
        if (w_adv[k]) begin
          r_sum <= w_acc;
          r_cy  <= w_cout;
          r_a   <= w_a_nx;
          r_b   <= w_b_nx;
        end
      end
    end else begin : g_out
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_sum <= '0;
          r_cy  <= 1'b0;
        end else if (w_adv[k]) begin
          r_sum <= w_acc;
          r_cy  <= w_cout;
        end
      end

`ifdef PIPE_ADDER_FLAGS_EN
      // The last slice still sees the operand MSBs, which is all V needs.
      flags_t r_flags;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_flags <= '0;
        end else if (w_adv[k]) begin
          r_flags <= calc_flags(w_acc, w_cout, w_a[C-1], w_b[C-1]);
        end
      end
`endif
    end
  end

  assign out_sum  = g_stage[STAGES-1].r_sum;
  assign out_cout = g_stage[STAGES-1].r_cy;

`ifdef PIPE_ADDER_FLAGS_EN
  assign out_flags = g_stage[STAGES-1].g_out.r_flags;
`else
  assign out_flags = '0;
`endif

endmodule

// File: tb/tb_pipe_adder.sv
// Scoreboard bench for pipe_adder (WIDTH=32, STAGES=4) with hand-computed vectors.
module tb_pipe_adder;

  localparam int WIDTH  = 32;
  localparam int STAGES = 4;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_sub;
  logic             in_cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic [3:0]       out_flags;

  pipe_adder #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_sub    (in_sub),
    .in_cin    (in_cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .out_flags (out_flags)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic        cin;
    logic [31:0] sum;
    logic        cout;
    logic [3:0]  f;
  } vec_t;

  typedef struct {
    logic [31:0] sum;
    logic        cout;
    logic [3:0]  f;
    int          cyc;
    bit          lat;
  } exp_t;

  vec_t        tv[12];
  exp_t        q[$];
  exp_t        m_e;
  int          n_chk = 0;
  int          n_err = 0;
  int          cyc = 0;
  logic [31:0] e_sum;
  logic        e_cout;
  logic [3:0]  e_f;
  bit          e_lat;
  bit          saw_ir_low;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [3:0] exp_flags(input logic [3:0] f);
`ifdef PIPE_ADDER_FLAGS_EN
    return f;
`else
    return 4'b0000;
`endif
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  // Monitor: pops on every output transfer, checks held output while stalled.
  always @(negedge clk) begin
    if (reset_n && out_valid) begin
      if (q.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL unexpected_output: got sum=%h with nothing outstanding", out_sum);
      end else if (out_ready) begin
        m_e = q.pop_front();
        chk("result", {27'd0, out_sum, out_cout, out_flags}, {27'd0, m_e.sum, m_e.cout, m_e.f});
        if (m_e.lat) chk("latency", 64'(cyc - m_e.cyc), 64'(STAGES));
      end else begin
        chk("stall_hold", {27'd0, out_sum, out_cout, out_flags},
            {27'd0, q[0].sum, q[0].cout, q[0].f});
      end
    end
    if (in_valid && !in_ready) saw_ir_low = 1'b1;
    if (reset_n && in_valid && in_ready)
      q.push_back('{e_sum, e_cout, exp_flags(e_f), cyc, e_lat});
  end

  task automatic send(input vec_t v, input bit lat);
    bit acc;
    in_a     = v.a;
    in_b     = v.b;
    in_sub   = v.sub;
    in_cin   = v.cin;
    e_sum    = v.sum;
    e_cout   = v.cout;
    e_f      = v.f;
    e_lat    = lat;
    in_valid = 1'b1;
    acc      = 1'b0;
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge clk);
      if (in_ready) acc = 1'b1;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (!acc) begin
      n_chk++;
      n_err++;
      $display("FAIL accept_timeout: got in_ready=0 for 50 cycles want 1");
    end
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 100 && q.size() != 0; i++) @(posedge clk);
    #1;
    chk("drain", 64'(q.size()), 64'd0);
  endtask

  initial begin
    tv[0]  = '{32'h0000_0005, 32'h0000_0003, 1'b0, 1'b0, 32'h0000_0008, 1'b0, 4'b0000};
    tv[1]  = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 4'b0110};
    tv[2]  = '{32'h0000_0005, 32'h0000_0007, 1'b1, 1'b0, 32'hFFFF_FFFE, 1'b0, 4'b1000};
    tv[3]  = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 4'b1001};
    tv[4]  = '{32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0002, 1'b0, 4'b0000};
    tv[5]  = '{32'h0000_000A, 32'h0000_000A, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 4'b0110};
    tv[6]  = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 4'b0111};
    tv[7]  = '{32'h1234_5678, 32'h1111_1111, 1'b0, 1'b1, 32'h2345_678A, 1'b0, 4'b0000};
    tv[8]  = '{32'h0000_0000, 32'h0000_0001, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b0, 4'b1000};
    tv[9]  = '{32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, 32'h7FFF_FFFF, 1'b1, 4'b0011};
    tv[10] = '{32'hFFFF_0000, 32'h0000_FFFF, 1'b0, 1'b0, 32'hFFFF_FFFF, 1'b0, 4'b1000};
    tv[11] = '{32'h0000_0003, 32'h0000_0003, 1'b1, 1'b1, 32'h0000_0000, 1'b1, 4'b0110};

    reset_n    = 1'b0;
    in_valid   = 1'b0;
    in_a       = '0;
    in_b       = '0;
    in_sub     = 1'b0;
    in_cin     = 1'b0;
    out_ready  = 1'b1;
    e_sum      = '0;
    e_cout     = 1'b0;
    e_f        = '0;
    e_lat      = 1'b0;
    saw_ir_low = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_sum", 64'(out_sum), 64'd0);
    chk("rst_out_cout", 64'(out_cout), 64'd0);
    chk("rst_out_flags", 64'(out_flags), 64'd0);
    reset_n = 1'b1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);

    // Isolated ops: add, full carry ripple, subtract to negative, signed overflow
    for (int i = 0; i < 4; i++) begin
      send(tv[i], 1'b1);
      wait_drain();
    end

    // Back-to-back stream with a three-cycle output stall in the middle
    saw_ir_low = 1'b0;
    fork
      begin
        for (int i = 4; i < 12; i++) send(tv[i], 1'b0);
      end
      begin
        repeat (5) @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    wait_drain();
    chk("in_ready_dropped", 64'(saw_ir_low), 64'd1);

    // Three ops in flight behind a stalled output, then asynchronous reset
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(tv[i], 1'b0);
    repeat (4) @(posedge clk);
    #1;
    chk("pre_reset_valid", 64'(out_valid), 64'd1);
    reset_n = 1'b0;
    #1;
    chk("async_reset_valid", 64'(out_valid), 64'd0);
    chk("async_reset_sum", 64'(out_sum), 64'd0);
    q.delete();
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    reset_n   = 1'b1;
    chk("post_reset_in_ready", 64'(in_ready), 64'd1);
    chk("post_reset_valid", 64'(out_valid), 64'd0);
    repeat (STAGES + 2) @(posedge clk);
    #1;
    send(tv[1], 1'b1);
    wait_drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule
